regfile_sb: RTL

- Parametrised successor to the pipeline's integer register file.
- Provides 2 combinational read ports and 1 write port.
- Adds optional write-to-read bypass, a per-register busy scoreboard for hazard detection, and a cycle-by-cycle register dump engine that replaces simulation-only register printing.
- Sits between decode (reads and reservations) and writeback (write port).

---
 rtl/regfile_sb.sv | 134 +++++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// Integer register file with two combinational read ports, one write port, optional
// write-to-read bypass, a per-register busy scoreboard and a sequential register dump engine.
module regfile_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_rd_addr1,
    input  logic [ADDR_W-1:0] i_rd_addr2,
    output logic [DATA_W-1:0] o_rd_data1,
    output logic [DATA_W-1:0] o_rd_data2,
    output logic              o_rd_busy1,
    output logic              o_rd_busy2,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rsv_en,
    input  logic [ADDR_W-1:0] i_rsv_addr,
    input  logic              i_dump_start,
    output logic              o_dump_valid,
    output logic [ADDR_W-1:0] o_dump_idx,
    output logic [DATA_W-1:0] o_dump_data,
    output logic              o_dump_done
);

    localparam int unsigned       DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic {StIdle, StScan} state_e;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_d;
    logic [ADDR_W-1:0] r_cnt;
    state_e            r_state;

    logic w_wr_ok;
    logic w_rsv_ok;

    assign w_wr_ok  = i_wr_en  && !(ZERO_REG && (i_wr_addr  == '0));
    assign w_rsv_ok = i_rsv_en && !(ZERO_REG && (i_rsv_addr == '0));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    // Reservation is applied after the writeback clear so a new producer keeps the bit set.
    always_comb begin
        w_busy_d = r_busy;
        if (i_wr_en) begin
            w_busy_d[i_wr_addr] = 1'b0;
        end
        if (w_rsv_ok) begin
            w_busy_d[i_rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_d;
        end
    end

    always_comb begin
        o_rd_data1 = r_regs[i_rd_addr1];
        if (BYPASS && w_wr_ok && (i_wr_addr == i_rd_addr1)) begin
            o_rd_data1 = i_wr_data;
        end
        if (ZERO_REG && (i_rd_addr1 == '0)) begin
            o_rd_data1 = '0;
        end
    end

    always_comb begin
        o_rd_data2 = r_regs[i_rd_addr2];
        if (BYPASS && w_wr_ok && (i_wr_addr == i_rd_addr2)) begin
            o_rd_data2 = i_wr_data;
        end
        if (ZERO_REG && (i_rd_addr2 == '0)) begin
            o_rd_data2 = '0;
        end
    end

    // A same-cycle writeback resolves the hazard; same-cycle reservations stay invisible.
    assign o_rd_busy1 = r_busy[i_rd_addr1] && !(i_wr_en && (i_wr_addr == i_rd_addr1));
    assign o_rd_busy2 = r_busy[i_rd_addr2] && !(i_wr_en && (i_wr_addr == i_rd_addr2));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            o_dump_valid <= 1'b0;
            o_dump_idx   <= '0;
            o_dump_data  <= '0;
            o_dump_done  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    o_dump_valid <= 1'b0;
                    o_dump_done  <= 1'b0;
                    if (i_dump_start) begin
                        r_state <= StScan;
                        r_cnt   <= '0;
                    end
                end
                StScan: begin
                    o_dump_valid <= 1'b1;
                    o_dump_idx   <= r_cnt;
                    o_dump_data  <= (ZERO_REG && (r_cnt == '0)) ? '0 : r_regs[r_cnt];
                    if (r_cnt == LAST) begin
                        o_dump_done <= 1'b1;
                        r_state     <= StIdle;
                    end else begin
                        o_dump_done <= 1'b0;
                        r_cnt       <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
